// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and execute-stage state encoding shared with the decoder
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_multiplier.sv
// alu_seq_multiplier: shift-add multiplier producing the low WIDTH product bits over WIDTH cycles
module alu_seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Load,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Product,
    output logic             Last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_run;

    // Product is the accumulator after this cycle's add, so the top can capture it on the final edge
    assign Product = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign Last    = r_run && (r_cnt == CW'(WIDTH - 1));

    // Load operands on acceptance, then iterate one bit per cycle until the last iteration
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (Load) begin
            r_mcand  <= A;
            r_mplier <= B;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b1;
        end else if (r_run) begin
            r_acc    <= Product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            r_run    <= !Last;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage with single-cycle ADD/SUB/SLT and an iterative MUL that stalls via Busy
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Done,
    output logic             Busy
);

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_mul_start;
    logic             w_single;
    logic             w_lt;
    logic             w_last;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_product;

    assign w_accept    = (r_state == S_IDLE) && Start;
    assign w_mul_start = w_accept && (ALUControl == ALU_MUL);
    assign w_single    = w_accept && (ALUControl != ALU_MUL);
    assign w_lt        = $signed(SrcA) < $signed(SrcB);
    assign Busy        = RST && (w_mul_start || (r_state == S_MUL));

    // Single-cycle datapath; unknown codes fall through to ADD
    always_comb begin
        w_alu = (ALUControl == ALU_SUB) ? SrcA - SrcB :
                (ALUControl == ALU_SLT) ? {{(WIDTH-1){1'b0}}, w_lt} :
                                          SrcA + SrcB;
    end

    alu_seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .CLK     (CLK),
        .RST     (RST),
        .Load    (w_mul_start),
        .A       (SrcA),
        .B       (SrcB),
        .Product (w_product),
        .Last    (w_last)
    );

    // Next state: enter MUL on an accepted multiply, leave after the final iteration
    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE && w_mul_start)
            w_next = S_MUL;
        else if (r_state == S_MUL && w_last)
            w_next = S_IDLE;
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Result, Zero and Done change only on a completion; Done is a one-cycle pulse
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALUResult <= '0;
            Zero      <= 1'b1;
            Done      <= 1'b0;
        end else begin
            Done <= w_single || (r_state == S_MUL && w_last);
            if (w_single) begin
                ALUResult <= w_alu;
                Zero      <= (w_alu == '0);
            end else if (r_state == S_MUL && w_last) begin
                ALUResult <= w_product;
                Zero      <= (w_product == '0);
            end
        end
    end

endmodule
